mosquito_wave_controller: RTL
=============================

// Module: mosquito_wave_controller
// PURPOSE
//  Owns the lifecycle of the two mosquito enemies: spawn scheduling, entry
//  descent, horizontal patrol, hit/death sequencing and respawn cooldown.
//  Drives the mosquito_x/y/alive arrays that feed the enemy-slot mapping
//  (enemy slots 21/22). Sits between the frame-tick generator, the collision
//  unit (hit pulses) and the renderer.
// PARAMETERS
//  SCREEN_W        640  visible width in pixels
//  SPRITE_W        32   mosquito sprite width; max x = SCREEN_W-SPRITE_W (608)
//  HOVER_Y         64   y row where descent ends and patrol begins
//  SPEED_X         2    px per frame_tick in HOVER
//  SPEED_Y         1    px per frame_tick in ENTER
//  INIT_DELAY      60   frames before first spawn after reset/game start (<256)
//  RESPAWN_FRAMES  120  cooldown frames after death (<256)
//  DYING_FRAMES    8    frames a slot stays in DYING (<256)
// PORTS
//  clk             in   1       system clock
//  rst_n           in   1       async active-low reset
//  game_active     in   1       level; low forces all slots to IDLE
//  frame_tick      in   1       1-cycle pulse per video frame
//  rng_x           in   10      free-running pseudo-random value
//  hit             in   2       1-cycle pulse per slot from collision unit
//  mosquito_x      out  10 [0:1] sprite left x per slot
//  mosquito_y      out  10 [0:1] sprite top y per slot
//  mosquito_alive  out  1  [0:1] high in ENTER/HOVER only
//  mosquito_dying  out  2       bit i high while slot i in DYING
//  spawn_pulse     out  1       1-cycle pulse when any slot spawns
// BEHAVIOUR
//  - Reset: all slots IDLE, x=0, y=0, alive=0, dying=0, spawn_pulse=0,
//    cooldown=INIT_DELAY, rr pointer=0, dir=right. All outputs registered;
//    every state change is visible the cycle after the triggering input.
//  - Per-slot FSM IDLE -> ENTER -> HOVER -> DYING -> IDLE; all timing advances
//    only on frame_tick except hit and game_active.
//  - IDLE: on frame_tick, cooldown>0 decrements; cooldown==0 marks slot ready.
//  - Spawn arbiter: at most one spawn per frame_tick. One ready slot: grant it.
//    Both ready: grant slot rr. After a grant rr = other slot. Granted slot:
//    ENTER, x = min(rng_x, SCREEN_W-SPRITE_W), y=0, dir = rng_x[0] (1=right),
//    spawn_pulse=1 for one cycle.
//  - ENTER: per tick y += SPEED_Y; when y+SPEED_Y >= HOVER_Y, y=HOVER_Y, go HOVER.
//  - HOVER: per tick x += / -= SPEED_X by dir. Right: if x+SPEED_X >= max x,
//    x=max x, dir=left. Left: if x < SPEED_X, x=0, dir=right. No
//    wrap-around or underflow, ever.
//  - hit[i] while slot i in ENTER/HOVER: DYING, alive=0, dying=1, x/y frozen,
//    counter=DYING_FRAMES. hit in IDLE/DYING ignored. hit same cycle as
//    frame_tick: hit wins, no move that cycle.
//  - DYING: per tick counter decrements; at 0 go IDLE, dying=0,
//    cooldown=RESPAWN_FRAMES.
//  - game_active low: every slot IDLE, alive=0, dying=0, cooldown=INIT_DELAY,
//    no spawns; priority over hit and frame_tick. Rising edge restarts countdown.
//  - Async reset mid-operation returns immediately to reset state.
// STRUCTURE
//  - mosquito_pkg: state enum {IDLE,ENTER,HOVER,DYING}, X_MAX localparam,
//    counter width (8).
//  - Sub-module mosquito_slot: one FSM+position+counters, instantiated twice;
//    top holds rr pointer, spawn arbiter, spawn_pulse.
// TESTING
//  1 Reset, game_active=1, rng_x=100: 60 ticks no spawn; tick 61 -> slot0
//    x=100,y=0,alive=1,spawn_pulse once. Tick 62 -> slot1 spawns.
//  2 Slot in ENTER, 64 ticks -> y=64, state HOVER; next tick x moves 2 px.
//  3 HOVER dir=right at x=607 -> tick gives x=608, dir=left; next tick x=606.
//    rng_x=1000 spawn -> x=608.
//  4 hit[0] with frame_tick same cycle in HOVER -> alive=0, dying[0]=1, x/y
//    unchanged; 8 ticks -> IDLE; respawn after 120 further ticks.
//  5 Both slots ready same tick -> only rr slot spawns; other spawns next
//    tick; rr alternates.
//  6 game_active low during HOVER/DYING -> all alive=0, dying=0 next cycle;
//    re-raise -> first spawn after 61 ticks. rst_n low mid-ENTER -> reset values.

Source files
------------

// File: rtl/mosquito_pkg.sv
// Shared types and constants for the mosquito enemy wave controller.
package mosquito_pkg;
    localparam int NUM_SLOTS = 2;
    localparam int POS_W     = 10;
    localparam int CNT_W     = 8;

    localparam int SCREEN_W = 640;
    localparam int SPRITE_W = 32;

    localparam logic [POS_W-1:0] X_MAX    = POS_W'(SCREEN_W - SPRITE_W);
    localparam logic [POS_W-1:0] HOVER_Y  = 10'd64;
    localparam logic [POS_W-1:0] SPEED_X  = 10'd2;
    localparam logic [POS_W-1:0] SPEED_Y  = 10'd1;

    localparam logic [CNT_W-1:0] INIT_DELAY     = 8'd60;
    localparam logic [CNT_W-1:0] RESPAWN_FRAMES = 8'd120;
    localparam logic [CNT_W-1:0] DYING_FRAMES   = 8'd8;

    typedef enum logic [1:0] {IDLE, ENTER, HOVER, DYING} slot_state_t;

    function automatic logic [POS_W-1:0] clamp_x(input logic [POS_W-1:0] v);
        return (v > X_MAX) ? X_MAX : v;
    endfunction
endpackage

// File: rtl/mosquito_wave_controller_slot.sv
// One mosquito slot: lifecycle FSM, position, direction and a shared
// cooldown/dying frame counter.
module mosquito_slot
    import mosquito_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             game_active,
    input  logic             frame_tick,
    input  logic             hit,
    input  logic             spawn,
    input  logic [POS_W-1:0] spawn_x,
    input  logic             spawn_dir,
    output logic             ready,
    output logic [POS_W-1:0] x,
    output logic [POS_W-1:0] y,
    output logic             alive,
    output logic             dying
);
    slot_state_t      state, state_nxt;
    logic [POS_W-1:0] x_nxt, y_nxt;
    logic             dir, dir_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;

    assign ready = (state == IDLE) && (cnt == '0);

    always_comb begin
        state_nxt = state;
        x_nxt     = x;
        y_nxt     = y;
        dir_nxt   = dir;
        cnt_nxt   = cnt;
        if (!game_active) begin
            state_nxt = IDLE;
            cnt_nxt   = INIT_DELAY;
        end else if (hit && (state == ENTER || state == HOVER)) begin
            // hit beats a coincident frame_tick: position stays frozen
            state_nxt = DYING;
            cnt_nxt   = DYING_FRAMES;
        end else if (frame_tick) begin
            unique case (state)
                IDLE: begin
                    if (spawn) begin
                        state_nxt = ENTER;
                        x_nxt     = spawn_x;
                        y_nxt     = '0;
                        dir_nxt   = spawn_dir;
                    end else if (cnt != '0) begin
                        cnt_nxt = cnt - 1'b1;
                    end
                end
                ENTER: begin
                    if (y + SPEED_Y >= HOVER_Y) begin
                        y_nxt     = HOVER_Y;
                        state_nxt = HOVER;
                    end else begin
                        y_nxt = y + SPEED_Y;
                    end
                end
                HOVER: begin
                    if (dir) begin
                        if (x + SPEED_X >= X_MAX) begin
                            x_nxt   = X_MAX;
                            dir_nxt = 1'b0;
                        end else begin
                            x_nxt = x + SPEED_X;
                        end
                    end else if (x < SPEED_X) begin
                        x_nxt   = '0;
                        dir_nxt = 1'b1;
                    end else begin
                        x_nxt = x - SPEED_X;
                    end
                end
                DYING: begin
                    if (cnt <= 8'd1) begin
                        state_nxt = IDLE;
                        cnt_nxt   = RESPAWN_FRAMES;
                    end else begin
                        cnt_nxt = cnt - 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            x     <= '0;
            y     <= '0;
            dir   <= 1'b1;
            cnt   <= INIT_DELAY;
            alive <= 1'b0;
            dying <= 1'b0;
        end else begin
            state <= state_nxt;
            x     <= x_nxt;
            y     <= y_nxt;
            dir   <= dir_nxt;
            cnt   <= cnt_nxt;
            alive <= (state_nxt == ENTER) || (state_nxt == HOVER);
            dying <= (state_nxt == DYING);
        end
    end
endmodule

// File: rtl/mosquito_wave_controller.sv
// Two-slot mosquito wave controller: round-robin spawn arbiter over two
// mosquito_slot instances.
module mosquito_wave_controller
    import mosquito_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             game_active,
    input  logic             frame_tick,
    input  logic [POS_W-1:0] rng_x,
    input  logic [1:0]       hit,
    output logic [POS_W-1:0] mosquito_x     [0:1],
    output logic [POS_W-1:0] mosquito_y     [0:1],
    output logic             mosquito_alive [0:1],
    output logic [1:0]       mosquito_dying,
    output logic             spawn_pulse
);
    logic [NUM_SLOTS-1:0] ready, grant;
    logic                 rr;
    logic [POS_W-1:0]     spawn_x;

    assign spawn_x = clamp_x(rng_x);

    always_comb begin
        grant = '0;
        if (game_active && frame_tick) begin
            if (ready[0] && ready[1]) grant[rr] = 1'b1;
            else                      grant     = ready;
        end
    end

    // rr points at the slot that did not win the last grant
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr          <= 1'b0;
            spawn_pulse <= 1'b0;
        end else begin
            spawn_pulse <= |grant;
            if (|grant) rr <= grant[0];
        end
    end

    for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
        mosquito_slot u_slot (
            .clk         (clk),
            .rst_n       (rst_n),
            .game_active (game_active),
            .frame_tick  (frame_tick),
            .hit         (hit[i]),
            .spawn       (grant[i]),
            .spawn_x     (spawn_x),
            .spawn_dir   (rng_x[0]),
            .ready       (ready[i]),
            .x           (mosquito_x[i]),
            .y           (mosquito_y[i]),
            .alive       (mosquito_alive[i]),
            .dying       (mosquito_dying[i])
        );
    end
endmodule
